plate_validator: RTL
====================

// Module: plate_validator
// PURPOSE
//  Front end of the parking exit path: collects a licence plate digit-by-digit,
//  matches it against a small programmable table of registered plates and
//  drives MatrVal towards the barrier controller. Holds off the next plate
//  until the barrier has opened (Barreira2=1) and closed again (Barreira2=0).
// PARAMETERS
//  DIGITS    4   digits per plate
//  N_PLATES  4   registered-plate table entries
//  HOLD      2   cycles MatrVal stays high per grant (>=1)
//  TIMEOUT   16  max cycles waiting for Barreira2 to rise after the grant
// PORTS
//  CLK        in   1           system clock, all logic on posedge
//  RST        in   1           synchronous, active-high reset
//  DigitIn    in   4           BCD digit, MSB digit first
//  DigitValid in   1           DigitIn valid; accepted when DigitValid&DigitReady
//  DigitReady out  1           high only in COLLECT
//  ProgEn     in   1           write table entry this cycle
//  ProgIdx    in   clog2(N_PLATES) table index
//  ProgPlate  in   4*DIGITS    plate value to store; entry marked valid
//  Barreira2  in   1           barrier state from barrier controller (1=open)
//  MatrVal    out  1           plate accepted, barrier open request
//  MatrInval  out  1           1-cycle pulse: plate rejected
//  Fault      out  1           1-cycle pulse: barrier failed to open in time
//  Busy       out  1           high in every state except COLLECT
// BEHAVIOUR
//  Reset: state=COLLECT, digit count=0, shift reg=0, all table valid bits=0,
//   DigitReady=1 on the first cycle after reset, MatrVal=MatrInval=Fault=0, Busy=0.
//  COLLECT: each accepted digit: plate<={plate[4*DIGITS-5:0],DigitIn}, cnt++.
//   DigitIn>9 sets sticky bad flag. After DIGITS-th digit -> CHECK (next cycle).
//  CHECK (1 cycle): hit = any entry valid && entry==plate && !bad.
//   hit -> GRANT; else -> DENY. Table write in same cycle: compare uses OLD contents.
//  DENY (1 cycle): MatrInval=1; clear cnt, bad, plate -> COLLECT.
//  GRANT: MatrVal=1 for exactly HOLD cycles -> WAIT_OPEN (MatrVal=0).
//   Barreira2 already 1 during GRANT counts as opened -> WAIT_CLOSE after HOLD.
//  WAIT_OPEN: Barreira2=1 -> WAIT_CLOSE; TIMEOUT cycles without it ->
//   Fault=1 one cycle, -> COLLECT.
//  WAIT_CLOSE: Barreira2=0 -> COLLECT (cnt, bad, plate cleared). No timeout.
//  Latency: last digit accepted at cycle n -> MatrVal/MatrInval high at n+2.
//  Table: ProgEn writes in any state incl. reset-deasserted first cycle; same
//   index written twice in a row: last write wins. RST overrides ProgEn.
//  Duplicate entries legal; match on any. Counters saturate-free, sized
//   clog2(max(DIGITS,HOLD,TIMEOUT)+1).
//  RST mid-operation (any state): immediate return to reset values, MatrVal
//   drops the cycle after RST is sampled.
//  Digits presented while Busy are not accepted (DigitReady=0); source holds them.
// STRUCTURE
//  Shared package: state encoding (COLLECT,CHECK,DENY,GRANT,WAIT_OPEN,
//   WAIT_CLOSE), BCD digit width 4, plate width helper 4*DIGITS.
//  Sub-module plate_table: N_PLATES registers + valid bits, write port,
//   combinational parallel compare returning hit. FSM/counters in top.
// TESTING
//  1 Prog idx0=16'h1234; send 1,2,3,4 -> MatrInval=0, MatrVal=1 for 2 cycles
//    starting 2 cycles after digit 4; Busy=1; Barreira2 1 then 0 -> DigitReady=1.
//  2 Empty table, send 1,2,3,4 -> MatrInval pulse 1 cycle, MatrVal stays 0.
//  3 idx1=16'h9A00 stored; send 9,A,0,0 -> bad digit -> MatrInval, no grant.
//  4 Grant with Barreira2 held 0 -> Fault pulse exactly 16 cycles after MatrVal
//    falls, back to COLLECT; no MatrVal retry.
//  5 ProgEn idx0=16'h5555 in the CHECK cycle of plate 5555 (table empty) ->
//    MatrInval; resend 5,5,5,5 -> MatrVal.
//  6 Assert RST during GRANT and during WAIT_CLOSE -> MatrVal=0, table valid
//    bits cleared, previously stored 1234 now rejected.

Source files
------------

// File: rtl/plate_validator_pkg.sv
// Shared definitions for the plate validator: FSM state encoding, digit width
// and the width helpers used to size plates and counters.
package plate_validator_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_COLLECT    = 3'd0,
    ST_CHECK      = 3'd1,
    ST_DENY       = 3'd2,
    ST_GRANT      = 3'd3,
    ST_WAIT_OPEN  = 3'd4,
    ST_WAIT_CLOSE = 3'd5
  } state_e;

  function automatic int plate_w(input int digits);
    return DIGIT_W * digits;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/plate_validator_plate_table.sv
// Registered-plate table: N_PLATES entries with valid bits, one write port and
// a combinational parallel compare against the collected plate.
module plate_table
  import plate_validator_pkg::*;
#(
  parameter int N_PLATES = 4,
  parameter int PW       = 16,
  parameter int IW       = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [PW-1:0] i_wr_plate,
  input  logic [PW-1:0] i_key,
  output logic          o_hit
);

  logic [PW-1:0]       r_plate [N_PLATES];
  logic [N_PLATES-1:0] r_valid;

  // Table storage; reset clears every entry and has priority over a write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int i = 0; i < N_PLATES; i++) begin
        r_plate[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_plate[i_wr_idx] <= i_wr_plate;
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Parallel compare sees the contents before any same-cycle write
  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < N_PLATES; i++) begin
      if (r_valid[i] && (r_plate[i] == i_key)) begin
        o_hit = 1'b1;
      end else begin
        o_hit = o_hit;
      end
    end
  end

endmodule

// File: rtl/plate_validator.sv
// Exit-path plate validator: collects BCD digits, matches them against the
// programmable table and sequences the barrier handshake. All outputs registered.
module plate_validator
  import plate_validator_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int N_PLATES = 4,
  parameter int HOLD     = 2,
  parameter int TIMEOUT  = 16,
  localparam int PW      = plate_w(DIGITS),
  localparam int IW      = (N_PLATES > 1) ? $clog2(N_PLATES) : 1,
  localparam int CW      = $clog2(max3(DIGITS, HOLD, TIMEOUT) + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DIGIT_W-1:0] DigitIn,
  input  logic               DigitValid,
  output logic               DigitReady,
  input  logic               ProgEn,
  input  logic [IW-1:0]      ProgIdx,
  input  logic [PW-1:0]      ProgPlate,
  input  logic               Barreira2,
  output logic               MatrVal,
  output logic               MatrInval,
  output logic               Fault,
  output logic               Busy
);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_timer;
  logic [PW-1:0] r_plate;
  logic          r_bad;
  logic          r_opened;
  logic          w_hit;
  logic          w_opened;

  plate_table #(
    .N_PLATES (N_PLATES),
    .PW       (PW),
    .IW       (IW)
  ) u_table (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_wr_en    (ProgEn),
    .i_wr_idx   (ProgIdx),
    .i_wr_plate (ProgPlate),
    .i_key      (r_plate),
    .o_hit      (w_hit)
  );

  // Barrier seen open at any point of the grant window, including this cycle
  assign w_opened = r_opened | Barreira2;

  // Main sequencer: digit collection, decision, barrier handshake and outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_COLLECT;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_plate    <= '0;
      r_bad      <= 1'b0;
      r_opened   <= 1'b0;
      DigitReady <= 1'b1;
      MatrVal    <= 1'b0;
      MatrInval  <= 1'b0;
      Fault      <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      MatrInval <= 1'b0;
      Fault     <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (DigitValid) begin
            r_plate <= {r_plate[PW-DIGIT_W-1:0], DigitIn};
            if (DigitIn > 4'd9) begin
              r_bad <= 1'b1;
            end
            if (r_cnt == CW'(DIGITS - 1)) begin
              r_cnt      <= '0;
              r_state    <= ST_CHECK;
              DigitReady <= 1'b0;
              Busy       <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          r_timer  <= '0;
          r_opened <= 1'b0;
          if (w_hit && !r_bad) begin
            r_state <= ST_GRANT;
            MatrVal <= 1'b1;
          end else begin
            r_state   <= ST_DENY;
            MatrInval <= 1'b1;
          end
        end
        ST_GRANT: begin
          r_opened <= w_opened;
          if (r_timer == CW'(HOLD - 1)) begin
            MatrVal <= 1'b0;
            r_timer <= '0;
            r_state <= w_opened ? ST_WAIT_CLOSE : ST_WAIT_OPEN;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_OPEN: begin
          if (Barreira2) begin
            r_state <= ST_WAIT_CLOSE;
          end else if (r_timer == CW'(TIMEOUT - 1)) begin
            Fault      <= 1'b1;
            r_state    <= ST_COLLECT;
            r_cnt      <= '0;
            r_bad      <= 1'b0;
            r_plate    <= '0;
            DigitReady <= 1'b1;
            Busy       <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_CLOSE: begin
          if (!Barreira2) begin
            r_state    <= ST_COLLECT;
            r_cnt      <= '0;
            r_bad      <= 1'b0;
            r_plate    <= '0;
            DigitReady <= 1'b1;
            Busy       <= 1'b0;
          end
        end
        default: begin
          // ST_DENY and any unreachable encoding both recover to COLLECT
          r_state    <= ST_COLLECT;
          r_cnt      <= '0;
          r_bad      <= 1'b0;
          r_plate    <= '0;
          MatrVal    <= 1'b0;
          DigitReady <= 1'b1;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
